// File: rtl/frame_loader_pkg.sv
// -----------------------------------------------------------------------------
// frame_loader_pkg
// Constants and state encoding shared by the frame loader and the VGA display
// stage. The display stage reads pixels back at addr = y*H_ACTIVE + x.
// Optional feature macro: FRAME_LOADER_CHECKSUM_EN adds the CHK state.
// -----------------------------------------------------------------------------
package frame_loader_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 12;

  // Encodings are pinned so the CHK state does not disturb the others.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    DONE = 3'd3
`ifdef FRAME_LOADER_CHECKSUM_EN
    , CHK = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/frame_loader_timeout.sv
// -----------------------------------------------------------------------------
// frame_loader_timeout
// Loadable down-counter that flags an idle gap between received bytes.
//   clk, rst : clock, asynchronous active-high reset (counter -> 0)
//   load     : reload to TIMEOUT_CYCLES-1 (a byte was accepted)
//   run      : count down while a frame is in progress
//   expire   : high in the TIMEOUT_CYCLES-th consecutive idle cycle
// -----------------------------------------------------------------------------
module frame_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the expiry cycle reloads the counter and wins.
  assign expire = run && !load && (cnt_q == '0);

endmodule

// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
// Receives a UART byte stream, waits for SYNC_BYTE, then packs byte pairs
// {R,G},{x,B} into RGB444 pixels written linearly into the frame buffer.
//   vga_clk    : 25 MHz pixel clock
//   rst        : asynchronous active-high reset
//   rx_valid   : one-cycle strobe, rx_data holds a byte
//   rx_data    : received byte
//   abort      : drop the current frame (priority over rx_valid)
//   wr_en      : BRAM write strobe, one cycle after the LO byte
//   wr_addr    : pixel address 0..H_ACTIVE*V_ACTIVE-1
//   wr_data    : pixel {R[3:0],G[3:0],B[3:0]}
//   busy       : frame in progress
//   frame_done : one-cycle pulse after a complete frame
//   err        : sticky timeout/checksum error, cleared by the next SYNC_BYTE
// Optional feature macro: FRAME_LOADER_CHECKSUM_EN -- an extra trailer byte
// must equal the XOR of all pixel bytes before frame_done is raised.
// -----------------------------------------------------------------------------
module frame_loader #(
  parameter int         H_ACTIVE       = frame_loader_pkg::H_ACTIVE,
  parameter int         V_ACTIVE       = frame_loader_pkg::V_ACTIVE,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2500000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        abort,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  import frame_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]        rg_q, rg_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic timer_run;
  logic timeout_expire;

  frame_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (vga_clk),
    .rst    (rst),
    .load   (rx_valid),
    .run    (timer_run),
    .expire (timeout_expire)
  );

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    rg_d         = rg_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    timer_run    = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      HI, LO: timer_run = 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
      CHK:    timer_run = 1'b1;
`endif
      default: timer_run = 1'b0;
    endcase

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_d   = HI;
            err_d     = 1'b0;
            pix_cnt_d = '0;
            busy_d    = 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_d    = '0;
`endif
          end
        end
        HI: begin
          if (rx_valid) begin
            rg_d    = rx_data;
            state_d = LO;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ rx_data;
`endif
          end
        end
        LO: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_cnt_q;
            wr_data_d = {rg_q, rx_data[3:0]};
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_d    = csum_q ^ rx_data;
`endif
            if (pix_cnt_q == LAST_PIX) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else begin
              pix_cnt_d = pix_cnt_q + ADDR_W'(1);
              state_d   = HI;
            end
          end
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        CHK: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_d = DONE;
            end else begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
`endif
        DONE: begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Only asserted in HI/LO/CHK cycles without a byte.
      if (timeout_expire) begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      rg_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      rg_q         <= rg_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
